// File: rtl/ofz_inp_sequencer.sv
// Feeder for the OFZ inner-product accumulator: sample delay line + coefficient RAM,
// drives frame 1..LEN with aligned operands, captures the sum and hands it over valid/ready.
module ofz_inp_sequencer #(
  parameter int unsigned LEN   = 126,
  parameter int unsigned DEPTH = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] smp_in,
  input  logic               smp_valid,
  input  logic               coef_wr_en,
  input  logic        [6:0]  coef_wr_addr,
  input  logic signed [19:0] coef_wr_data,
  input  logic               start,
  output logic               busy,
  output logic        [6:0]  frame,
  output logic signed [15:0] in_1,
  output logic signed [19:0] in_2,
  input  logic signed [35:0] acc_in,
  output logic signed [35:0] result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               overrun
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [6:0]  LEN7 = 7'(LEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CAPTURE, S_HOLD} state_t;

  state_t             r_state;
  logic signed [15:0] r_smp_mem  [DEPTH];
  logic signed [19:0] r_coef_mem [LEN];
  logic [AW-1:0]      r_wp;
  logic [AW-1:0]      r_base;
  logic [6:0]         r_idx;
  logic               r_busy;
  logic [6:0]         r_frame;
  logic signed [15:0] r_in_1;
  logic signed [19:0] r_in_2;
  logic signed [35:0] r_result;
  logic               r_result_valid;
  logic               r_overrun;
  logic [AW-1:0]      w_rd_addr;

  // Reads walk backwards from the base latched at start, so writes during a run don't shift the window.
  assign w_rd_addr = r_base - AW'(r_idx);

  always_ff @(posedge clk) begin
    if (smp_valid) r_smp_mem[r_wp] <= smp_in;
  end

  always_ff @(posedge clk) begin
    if (coef_wr_en && (coef_wr_addr < LEN7)) r_coef_mem[coef_wr_addr] <= coef_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wp <= '0;
    else if (smp_valid) r_wp <= r_wp + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_base         <= '0;
      r_idx          <= '0;
      r_busy         <= 1'b0;
      r_frame        <= '0;
      r_in_1         <= '0;
      r_in_2         <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_overrun <= start && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base  <= r_wp - AW'(1);
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_idx == LEN7) begin
            r_frame <= '0;
            r_in_1  <= '0;
            r_in_2  <= '0;
            r_state <= S_CAPTURE;
          end else begin
            r_frame <= r_idx + 7'd1;
            r_in_1  <= r_smp_mem[w_rd_addr];
            r_in_2  <= r_coef_mem[r_idx];
            r_idx   <= r_idx + 7'd1;
          end
        end
        S_CAPTURE: begin
          r_result       <= acc_in;
          r_result_valid <= 1'b1;
          r_state        <= S_HOLD;
        end
        S_HOLD: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_state        <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign frame        = r_frame;
  assign in_1         = r_in_1;
  assign in_2         = r_in_2;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign overrun      = r_overrun;

endmodule
